// File: rtl/fsm_3state.sv
// Moore detector for runs of consecutive 1s on a serial input.
// out is high while two or more 1s in a row have been sampled.
module fsm_3state (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [1:0] state,
  output logic [1:0] next_state,
  output logic       out
);

  typedef enum logic [1:0] {
    S0   = 2'b00,
    S1   = 2'b01,
    S2   = 2'b10,
    SBAD = 2'b11
  } state_t;

  logic [1:0] state_q;

  // State register; reset wins over any transition
  always_ff @(posedge clk) begin
    if (reset) state_q <= S0;
    else       state_q <= next_state;
  end

  // Next state from (state, in); the unused code falls back to idle
  always_comb begin
    next_state = S0;
    unique case (state_q)
      S0:      next_state = in ? S1 : S0;
      S1:      next_state = in ? S2 : S0;
      S2:      next_state = in ? S2 : S0;
      default: next_state = S0;
    endcase
  end

  // Moore output depends only on the registered state
  always_comb begin
    out = (state_q == S2);
  end

  assign state = state_q;

endmodule

// File: tb/tb_fsm_3state.sv
// Directed bench for fsm_3state.
// Expected values are hand-derived from the transition table.
module tb_fsm_3state;

  logic       clk;
  logic       reset;
  logic       in;
  logic [1:0] state;
  logic [1:0] next_state;
  logic       out;

  int checks = 0;
  int errors = 0;

  fsm_3state dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .state     (state),
    .next_state(next_state),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [1:0] obs,
                     input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic edge1(input logic r, input logic d);
    reset = r;
    in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag,
                      input logic [1:0] s,
                      input logic [1:0] ns,
                      input logic o);
    chk({tag, ".state"}, state, s);
    chk({tag, ".next"}, next_state, ns);
    chk({tag, ".out"}, {1'b0, out}, {1'b0, o});
  endtask

  initial begin
    reset = 1'b1;
    in    = 1'b1;
    #2;

    // 1: reset edge, then one in=0 edge
    edge1(1'b1, 1'b1);
    chk("rst_state", state, 2'b00);
    chk("rst_out", {1'b0, out}, 2'b00);
    edge1(1'b0, 1'b0);
    chk3("idle", 2'b00, 2'b00, 1'b0);
    in = 1'b1;
    #1;
    chk("idle_ns_in1", next_state, 2'b01);

    // 2: first 1
    edge1(1'b0, 1'b1);
    chk3("one", 2'b01, 2'b10, 1'b0);

    // 3: second 1, then hold the run
    edge1(1'b0, 1'b1);
    chk3("run", 2'b10, 2'b10, 1'b1);
    for (int i = 0; i < 5; i++) begin
      edge1(1'b0, 1'b1);
      chk3("run_hold", 2'b10, 2'b10, 1'b1);
    end

    // 4: a 0 drops back to idle
    in = 1'b0;
    #1;
    chk("run_ns_in0", next_state, 2'b00);
    edge1(1'b0, 1'b0);
    chk3("drop", 2'b00, 2'b00, 1'b0);
    edge1(1'b0, 1'b0);
    chk3("drop2", 2'b00, 2'b00, 1'b0);

    // 1-0-1 must not reach RUN
    edge1(1'b0, 1'b1);
    edge1(1'b0, 1'b0);
    chk3("gap", 2'b00, 2'b00, 1'b0);
    edge1(1'b0, 1'b1);
    chk3("gap_one", 2'b01, 2'b10, 1'b0);

    // 5: reset mid-run
    edge1(1'b0, 1'b1);
    chk3("rerun", 2'b10, 2'b10, 1'b1);
    edge1(1'b1, 1'b1);
    chk("midrst_state", state, 2'b00);
    chk("midrst_out", {1'b0, out}, 2'b00);
    edge1(1'b0, 1'b0);
    chk3("post_rst", 2'b00, 2'b00, 1'b0);

    // 6: illegal code recovers to idle
    force dut.state_q = 2'b11;
    in = 1'b0;
    #1;
    chk3("bad_in0", 2'b11, 2'b00, 1'b0);
    in = 1'b1;
    #1;
    chk3("bad_in1", 2'b11, 2'b00, 1'b0);
    release dut.state_q;
    edge1(1'b0, 1'b1);
    chk3("bad_recover", 2'b00, 2'b01, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
